// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - shared constants and encodings for the SRAM request arbiter
package sram_req_arbiter_pkg;

    localparam int OT_DEPTH_DEF = 4;

    typedef enum logic {
        M_DATA = 1'b0,
        M_INST = 1'b1
    } master_id_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } grant_state_e;

endpackage

// File: rtl/sram_req_arbiter_ot_id_fifo.sv
// rtl/sram_req_arbiter_ot_id_fifo.sv - outstanding-transaction FIFO of 1-bit master IDs
module ot_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_push,
    input  logic i_push_id,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Full/empty are registered state, so a same-cycle pop never frees a slot for a push.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_id;
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-master SRAM-like request arbiter with in-order response routing
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OT_DEPTH = OT_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic [31:0] m1_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    output logic        proto_err
);
    grant_state_e r_state;
    grant_state_e w_next;
    master_id_e   w_gnt_id;
    logic         w_gnt_vld;
    logic         w_gnt_req;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    logic         w_head;
    logic         r_proto_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_gnt_id  = M_DATA;
        w_gnt_vld = 1'b0;
        case (r_state)
            ST_LOCK0: begin w_gnt_id = M_DATA; w_gnt_vld = 1'b1; end
            ST_LOCK1: begin w_gnt_id = M_INST; w_gnt_vld = 1'b1; end
            default: begin
                if (m0_req)      begin w_gnt_id = M_DATA; w_gnt_vld = 1'b1; end
                else if (m1_req) begin w_gnt_id = M_INST; w_gnt_vld = 1'b1; end
            end
        endcase
        w_gnt_req = w_gnt_vld & ((w_gnt_id == M_INST) ? m1_req : m0_req);
        s_req     = w_gnt_req & ~w_full & resetn;
        w_push    = s_req & s_addr_ok;

        // A full FIFO freezes the lock so a stalled master keeps its place.
        w_next = r_state;
        if (!w_full) begin
            case (r_state)
                ST_LOCK0, ST_LOCK1: if (w_push || !w_gnt_req) w_next = ST_IDLE;
                default: if (w_gnt_vld && !w_push)
                             w_next = (w_gnt_id == M_INST) ? ST_LOCK1 : ST_LOCK0;
            endcase
        end
    end

    assign s_wr    = (w_gnt_id == M_INST) ? m1_wr    : m0_wr;
    assign s_size  = (w_gnt_id == M_INST) ? m1_size  : m0_size;
    assign s_addr  = (w_gnt_id == M_INST) ? m1_addr  : m0_addr;
    assign s_wdata = (w_gnt_id == M_INST) ? m1_wdata : m0_wdata;
    assign s_wstrb = (w_gnt_id == M_INST) ? m1_wstrb : m0_wstrb;

    assign m0_addr_ok = w_push & (w_gnt_id == M_DATA);
    assign m1_addr_ok = w_push & (w_gnt_id == M_INST);

    ot_id_fifo #(.DEPTH(OT_DEPTH)) u_ot_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .i_push   (w_push),
        .i_push_id(w_gnt_id),
        .i_pop    (s_data_ok),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_head   (w_head)
    );

    assign m0_data_ok = s_data_ok & ~w_empty & (w_head == M_DATA);
    assign m1_data_ok = s_data_ok & ~w_empty & (w_head == M_INST);
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                 r_proto_err <= 1'b0;
        else if (s_data_ok & w_empty) r_proto_err <= 1'b1;
    end
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - randomized bench for sram_req_arbiter against a queue-based model
module tb_sram_req_arbiter;
    localparam int OT_DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size, s_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr, s_addr_ok, s_data_ok, proto_err;
    logic [31:0] s_addr, s_wdata, s_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    int mq[$];
    int owner;
    bit perr;

    sram_req_arbiter #(.OT_DEPTH(OT_DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic randomize_inputs(input int p_req, input int p_aok, input int p_dok);
        m0_req    = ($urandom_range(0, 99) < p_req);
        m1_req    = ($urandom_range(0, 99) < p_req);
        m0_wr     = 1'($urandom);
        m1_wr     = 1'($urandom);
        m0_size   = 2'($urandom);
        m1_size   = 2'($urandom);
        m0_addr   = $urandom;
        m1_addr   = $urandom;
        m0_wdata  = $urandom;
        m1_wdata  = $urandom;
        m0_wstrb  = 4'($urandom);
        m1_wstrb  = 4'($urandom);
        s_addr_ok = ($urandom_range(0, 99) < p_aok);
        s_data_ok = ($urandom_range(0, 99) < p_dok);
        s_rdata   = $urandom;
    endtask

    // Evaluate one cycle: check combinational outputs, then advance the model at the edge.
    task automatic run_cycle(input bit rst_now, input int p_req, input int p_aok, input int p_dok);
        bit full, empty, greq, push, pop_ok;
        int gnt, head;
        @(negedge clk);
        resetn = !rst_now;
        randomize_inputs(p_req, p_aok, p_dok);
        if (rst_now) begin
            mq.delete();
            owner = -1;
            perr  = 0;
        end
        #1;
        full  = (mq.size() == OT_DEPTH);
        empty = (mq.size() == 0);
        head  = empty ? -1 : mq[0];
        if (owner >= 0)  gnt = owner;
        else if (m0_req) gnt = 0;
        else if (m1_req) gnt = 1;
        else             gnt = -1;
        greq   = (gnt == 0) ? m0_req : (gnt == 1) ? m1_req : 1'b0;
        greq   = greq && !full && !rst_now;
        push   = greq && s_addr_ok;
        pop_ok = s_data_ok && !empty;

        check_eq("s_req", 32'(s_req), 32'(greq));
        check_eq("m0_addr_ok", 32'(m0_addr_ok), 32'(push && gnt == 0));
        check_eq("m1_addr_ok", 32'(m1_addr_ok), 32'(push && gnt == 1));
        check_eq("m0_data_ok", 32'(m0_data_ok), 32'(pop_ok && head == 0));
        check_eq("m1_data_ok", 32'(m1_data_ok), 32'(pop_ok && head == 1));
        check_eq("proto_err", 32'(proto_err), 32'(perr));
        check_eq("m0_rdata", m0_rdata, s_rdata_exp());
        check_eq("m1_rdata", m1_rdata, s_rdata_exp());
        if (greq) begin
            check_eq("s_addr",  s_addr,         (gnt == 1) ? m1_addr  : m0_addr);
            check_eq("s_wdata", s_wdata,        (gnt == 1) ? m1_wdata : m0_wdata);
            check_eq("s_wr",    32'(s_wr),      32'((gnt == 1) ? m1_wr    : m0_wr));
            check_eq("s_size",  32'(s_size),    32'((gnt == 1) ? m1_size  : m0_size));
            check_eq("s_wstrb", 32'(s_wstrb),   32'((gnt == 1) ? m1_wstrb : m0_wstrb));
        end

        @(posedge clk);
        if (!rst_now) begin
            if (pop_ok)         void'(mq.pop_front());
            else if (s_data_ok) perr = 1;
            if (push) mq.push_back(gnt);
            if (!full) begin
                if (owner >= 0) begin
                    if (push || !((owner == 0) ? m0_req : m1_req)) owner = -1;
                end else if (gnt >= 0 && !push) begin
                    owner = gnt;
                end
            end
        end
    endtask

    function automatic logic [31:0] s_rdata_exp();
        return s_rdata;
    endfunction

    initial begin
        owner  = -1;
        perr   = 0;
        resetn = 1'b0;
        randomize_inputs(0, 0, 0);
        run_cycle(1, 50, 50, 0);
        run_cycle(1, 50, 50, 50);
        for (int ph = 0; ph < 6; ph++) begin
            int p_dok;
            case (ph % 3)
                0:       p_dok = 5;
                1:       p_dok = 35;
                default: p_dok = 70;
            endcase
            for (int c = 0; c < 800; c++) begin
                run_cycle($urandom_range(0, 249) == 0, (ph < 3) ? 80 : 55,
                          (ph % 2 == 0) ? 70 : 35, p_dok);
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 Parameter: OT_DEPTH, 4, outstanding-transaction FIFO depth; power of two, range 2..8.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 m0_req/m0_wr/m0_size/m0_addr/m0_wdata/m0_wstrb  in  1/1/2/32/32/4  master 0 request bundle (data side, high priority).
REQ-005 m0_addr_ok/m0_data_ok/m0_rdata  out  1/1/32  master 0 response bundle.
REQ-006 m1_req/m1_wr/m1_size/m1_addr/m1_wdata/m1_wstrb  in  1/1/2/32/32/4  master 1 request bundle (inst side, low priority).
REQ-007 m1_addr_ok/m1_data_ok/m1_rdata  out  1/1/32  master 1 response bundle.
REQ-008 s_req/s_wr/s_size/s_addr/s_wdata/s_wstrb  out  1/1/2/32/32/4  shared slave request bundle.
REQ-009 s_addr_ok/s_data_ok/s_rdata  in  1/1/32  shared slave response bundle.
REQ-010 proto_err  out  1  sticky flag: s_data_ok received with no transaction outstanding.

Function
REQ-011 Request accepted ("push") in the cycle with s_req & s_addr_ok; the granted master's addr_ok SHALL equal s_addr_ok in that cycle, the other master's addr_ok SHALL be 0.
REQ-012 Grant FSM states: IDLE, LOCK0, LOCK1.
REQ-013 IDLE: grant m0 if m0_req, else m1 if m1_req, else none; same-cycle combinational grant, zero added latency.
REQ-014 IDLE -> LOCKx when master x is granted and not accepted this cycle; LOCKx holds grant on x regardless of the other master's req.
REQ-015 LOCKx -> IDLE on push; LOCKx -> IDLE also when x deasserts req, tolerated for masters cancelled by exception flush.
REQ-016 s_* request fields SHALL be a pure mux of the granted master; s_req = granted master's req & ~ot_full; no master granted -> s_req=0, other fields don't-care.
REQ-017 Outstanding FIFO of OT_DEPTH 1-bit master IDs; push writes the granted ID at the tail; s_data_ok pops the head ("pop").
REQ-018 Responses route in order: mx_data_ok = s_data_ok & ~ot_empty & (head ID == x); both mx_rdata = s_rdata, unmasked.
REQ-019 Count width clog2(OT_DEPTH)+1; pointers wrap modulo OT_DEPTH; full when count==OT_DEPTH, empty when count==0.
REQ-020 Full: s_req=0, both addr_ok=0, FSM lock state unchanged.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance; full with same-cycle pop still blocks push, since full is registered state.
REQ-022 Pop on empty: no pointer/count change, no data_ok to either master, proto_err set to 1 until reset.
REQ-023 A response SHALL be returned no earlier than the cycle after its push; a same-cycle push plus data_ok pops only prior entries.
REQ-024 Writes and reads share the FIFO; a write's data_ok is routed like a read's.

Reset
REQ-025 resetn low: FSM=IDLE, pointers=0, count=0, proto_err=0, FIFO contents don't-care.
REQ-026 Outputs under reset: s_req=0, m0/m1 addr_ok=0, m0/m1 data_ok=0.
REQ-027 Reset mid-operation discards all outstanding IDs; late s_data_ok after release with an empty FIFO follows REQ-022.

Structure
REQ-028 Shared package holds: OT_DEPTH default, master ID encoding (M_DATA=0, M_INST=1), FSM state encoding.
REQ-029 One sub-module, ot_id_fifo: parameterised ID FIFO with push/pop/full/empty/head outputs; FSM and muxing stay in the top.

Verification
REQ-030 m0_req and m1_req both high, s_addr_ok=1 -> s_addr=m0_addr, m0_addr_ok=1, m1_addr_ok=0; next cycle m1 granted.
REQ-031 m1_req high, s_addr_ok=0 for 3 cycles, m0_req rises in cycle 2 -> grant stays m1 (LOCK1) until accept, then m0.
REQ-032 Four reads pushed m0,m1,m1,m0 with s_addr_ok=1, data_ok withheld -> fifth request gets s_req=0; four data_ok pulses -> data_ok order m0,m1,m1,m0 with s_rdata passed through.
REQ-033 FIFO at count 2, push and pop in same cycle -> count stays 2, data_ok to head ID only.
REQ-034 s_data_ok pulse with empty FIFO -> no mx_data_ok, proto_err=1 and held.
REQ-035 resetn low for 1 cycle with 3 outstanding -> count=0, FSM=IDLE, proto_err=0; next request granted same cycle.
